bcd_tick_counter: RTL and testbench
===================================

# bcd_tick_counter

Multi-digit BCD up/down counter advanced by the divided clock output of the clock divider stage. It samples the slow square wave on the system clock, detects its rising edge, and turns each edge into one count step. Q drives the seven-segment display path directly. LD, UP and EN come from board switches and buttons.

## Interface
Parameters:
- DIGITS, default 4: number of BCD digits; count width is 4*DIGITS.

Ports:
- clk  in  1  system clock; the only clock in the block.
- RESET  in  1  synchronous, active-high reset.
- slow_in  in  1  divided square wave from the clock divider, in the clk domain.
- EN  in  1  count enable; gates ticks only, not LD.
- LD  in  1  synchronous parallel load of D.
- UP  in  1  direction: 1 = increment, 0 = decrement.
- D  in  4*DIGITS  BCD load value; digit 0 in D[3:0].
- Q  out  4*DIGITS  current BCD count; digit 0 in Q[3:0].
- TICK  out  1  one-clk pulse for each detected rising edge of slow_in.
- TC  out  1  one-clk terminal-count pulse.

## Operation
- Edge detect:
  - Two flops: s1 <= slow_in, s2 <= s1.
  - rise = s1 & ~s2.
  - TICK = rise, decoded from flops only, so it is glitch-free.
- Update priority per clk edge: RESET, then LD, then (EN & rise), then hold.
- RESET: Q = 0, s1 = s2 = 0, TC = 0.
  - If slow_in is already high at release, that counts as a rising edge.
- LD:
  - Q <= D, with any digit >9 clamped to 9.
  - A rise in the same cycle is discarded, and no TC is produced.
- Count up:
  - Digit 0 increments; 9 -> 0 generates a carry into the next digit.
  - Carries ripple within the same cycle.
- Count down:
  - Digit 0 decrements; 0 -> 9 generates a borrow into the next digit.
- Boundary:
  - Up at all-9s (9999 for DIGITS=4), or down at all-0s, is a boundary step.
  - TC <= 1 for exactly one cycle on a boundary step; otherwise TC <= 0.
  - Q behaviour at the boundary depends on the configuration (see below).
- An UP change takes effect on the next rise and needs no resynchronisation.
- Held digits are never invalid: every reachable Q value is legal BCD.

## Timing
- slow_in sampled high at edge k -> rise high during cycle k to k+1 -> Q and TC update at edge k+1.
- TICK is high during the same cycle as rise, one cycle before Q changes.
- Latency from the slow_in transition to Q: 2 clk edges.
- A slow_in high for one clk cycle still produces exactly one rise.
  - slow_in must be low for ≥1 sampled cycle between edges to be seen as a new edge.
- TC is registered: high for the cycle after the boundary step, then low.
- Q and TC are fully registered outputs.

## Configuration
- BCD_SATURATE_EN defined:
  - The boundary step holds Q: up stays at all-9s, down stays at all-0s.
  - TC still pulses on every boundary-step attempt.
- BCD_SATURATE_EN undefined (default):
  - The boundary step wraps: all-9s -> all-0s going up, all-0s -> all-9s going down.
  - TC pulses once per wrap.

## Structure
- Package bcd_tick_counter_pkg:
  - typedef bcd_t (logic [3:0]).
  - constants BCD_MAX = 4'd9 and BCD_MIN = 4'd0.
  - a function that clamps a nibble to BCD_MAX.
- Sub-module bcd_digit, instantiated DIGITS times in a generate loop:
  - Inputs: clk, RESET, ld, ld_val, step, up.
  - Outputs: q and carry_out.
  - carry_out is high when step is set and (up & q==9 | ~up & q==0).
  - The step of digit n+1 is the carry_out of digit n.
- The top level holds the edge detector, the boundary/TC logic and the saturate gating.

## Test plan
- Reset and edge detect: RESET for 2 cycles, then toggle slow_in every 3 clk with EN=1, UP=1, 4 rising edges -> Q=0004; TICK pulses 4 times; Q changes exactly 2 edges after each slow_in rise.
- Carry ripple: LD with D=0x0999, then 1 rise, UP=1 -> Q=0x1000, TC=0.
- Up wrap/saturate: LD 0x9999, then 1 rise, UP=1.
  - Without the macro: Q=0x0000, TC high for 1 cycle.
  - With BCD_SATURATE_EN: Q=0x9999, TC high for 1 cycle.
- Down borrow and wrap:
  - LD 0x1000, 1 rise, UP=0 -> Q=0x0999.
  - LD 0x0000, 1 rise, UP=0 -> Q=0x9999 (wrap build), TC pulse.
- Priority and clamp:
  - LD=1 with D=0xA3F5 in the same cycle as a rise -> Q=0x9395, no count step, TC=0.
  - EN=0 with 5 rises -> Q unchanged, TICK pulses 5 times.
- Reset mid-count: assert RESET while slow_in is high and Q=0x0042 -> Q=0x0000 next edge. One rise is counted after release while slow_in is still high -> Q=0x0001.

Source files
------------

// File: rtl/bcd_tick_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_tick_counter_pkg
//  Description : Shared BCD digit type, digit limits and the load clamp helper
//                used by bcd_tick_counter and bcd_digit.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_tick_counter_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;
   localparam bcd_t BCD_MIN = 4'd0;

   // Any nibble above 9 is forced to 9 so a loaded digit is always legal BCD.
   function automatic bcd_t clamp_bcd(input logic [3:0] nib);
      return (nib > BCD_MAX) ? BCD_MAX : nib;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD digit of the tick counter. Loads a clamped value or
//                steps up/down by one, wrapping 9->0 / 0->9, and flags a
//                carry/borrow into the next digit in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
   import bcd_tick_counter_pkg::*;
(
   input  logic clk,
   input  logic RESET,
   input  logic ld,
   input  bcd_t ld_val,
   input  logic step,
   input  logic up,
   output bcd_t q,
   output logic carry_out
);

   // Combinational so that a carry ripples through every digit in one cycle.
   assign carry_out = step & (up ? (q == BCD_MAX) : (q == BCD_MIN));

   // Digit register: reset, then load, then a single up/down step.
   always_ff @(posedge clk) begin
      if (RESET) begin
         q <= BCD_MIN;
      end else if (ld) begin
         q <= clamp_bcd(ld_val);
      end else if (step) begin
         if (up) begin
            q <= (q >= BCD_MAX) ? BCD_MIN : q + 4'd1;
         end else begin
            q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bcd_tick_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_tick_counter
//  Description : Multi-digit BCD up/down counter stepped once per rising edge
//                of the divided clock slow_in (sampled in the clk domain).
//                Provides a TICK pulse per detected edge and a registered
//                one-cycle terminal-count pulse TC on every boundary step.
//  Options     : BCD_SATURATE_EN - boundary steps hold Q instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_tick_counter
   import bcd_tick_counter_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  RESET,
   input  logic                  slow_in,
   input  logic                  EN,
   input  logic                  LD,
   input  logic                  UP,
   input  logic [4*DIGITS-1:0]   D,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  TICK,
   output logic                  TC
);

   logic              s1;
   logic              s2;
   logic              rise;
   logic              count_req;
   logic              boundary;
   logic [DIGITS:0]   carry;

   // Two-flop sampler of slow_in; reset to 0 so a high level at release is an edge.
   always_ff @(posedge clk) begin
      if (RESET) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= slow_in;
         s2 <= s1;
      end
   end

   assign rise      = s1 & ~s2;
   assign TICK      = rise;
   // A load in the same cycle swallows the edge entirely.
   assign count_req = EN & rise & ~LD;

`ifdef BCD_SATURATE_EN
   localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{BCD_MAX}};

   // Boundary is detected up front so the step can be suppressed and Q held.
   assign boundary = count_req & (UP ? (Q == ALL_NINES) : (Q == '0));
   assign carry[0] = count_req & ~boundary;
`else
   // Wrapping: a carry out of the top digit is exactly the boundary step.
   assign carry[0] = count_req;
   assign boundary = carry[DIGITS];
`endif

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         bcd_digit u_digit (
            .clk       (clk),
            .RESET     (RESET),
            .ld        (LD),
            .ld_val    (D[4*i +: 4]),
            .step      (carry[i]),
            .up        (UP),
            .q         (Q[4*i +: 4]),
            .carry_out (carry[i+1])
         );
      end
   endgenerate

   // Terminal-count pulse: one cycle after each boundary step, otherwise low.
   always_ff @(posedge clk) begin
      if (RESET) begin
         TC <= 1'b0;
      end else begin
         TC <= boundary;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bcd_tick_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_tick_counter
//  Description : Self-checking bench for bcd_tick_counter (DIGITS = 4).
//                Directed scenarios followed by randomized stimulus, all
//                compared every cycle against a decimal-integer reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_tick_counter;

   localparam int DIGITS = 4;
   localparam int MAXV   = 9999;

   logic        clk;
   logic        rst;
   logic        sl;
   logic        en;
   logic        ld;
   logic        up;
   logic [15:0] d;
   logic [15:0] q;
   logic        tick;
   logic        tc;

   int n_tests = 0;
   int n_fail  = 0;
   int tick_cnt = 0;
   int tc_cnt   = 0;

   // reference model state: count as a plain decimal integer
   int m_cnt = 0;
   bit m_prev1 = 0;   // slow_in sample from the last edge
   bit m_prev2 = 0;   // slow_in sample from the edge before
   bit m_tc = 0;

   bcd_tick_counter #(.DIGITS(DIGITS)) dut (
      .clk     (clk),
      .RESET   (rst),
      .slow_in (sl),
      .EN      (en),
      .LD      (ld),
      .UP      (up),
      .D       (d),
      .Q       (q),
      .TICK    (tick),
      .TC      (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int bcd2int(input logic [15:0] v);
      int r = 0;
      int w = 1;
      for (int i = 0; i < DIGITS; i++) begin
         int nib = int'(v[4*i +: 4]);
         if (nib > 9) nib = 9;
         r += nib * w;
         w *= 10;
      end
      return r;
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] r = '0;
      int t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Reference update for one clk edge, using the inputs present at that edge.
   task automatic model_edge();
      bit rise;
      if (rst) begin
         m_cnt = 0; m_prev1 = 0; m_prev2 = 0; m_tc = 0;
      end else begin
         rise = m_prev1 && !m_prev2;
         m_tc = 0;
         if (ld) begin
            m_cnt = bcd2int(d);
         end else if (en && rise) begin
            if (up) begin
               if (m_cnt == MAXV) begin
                  m_tc = 1;
`ifndef BCD_SATURATE_EN
                  m_cnt = 0;
`endif
               end else m_cnt = m_cnt + 1;
            end else begin
               if (m_cnt == 0) begin
                  m_tc = 1;
`ifndef BCD_SATURATE_EN
                  m_cnt = MAXV;
`endif
               end else m_cnt = m_cnt - 1;
            end
         end
         m_prev2 = m_prev1;
         m_prev1 = sl;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("Q", {16'h0, q}, {16'h0, int2bcd(m_cnt)});
      check("TC", {31'h0, tc}, {31'h0, m_tc});
      check("TICK", {31'h0, tick}, {31'h0, (m_prev1 & ~m_prev2)});
      if (tick === 1'b1) tick_cnt++;
      if (tc === 1'b1) tc_cnt++;
   endtask

   task automatic rise_pulse();
      sl = 1'b1;
      repeat (3) cycle();
      sl = 1'b0;
      repeat (3) cycle();
   endtask

   task automatic load(input logic [15:0] val);
      ld = 1'b1; d = val;
      cycle();
      ld = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sl = 1'b0; en = 1'b1; ld = 1'b0; up = 1'b1; d = '0;

      // reset and edge detection
      repeat (2) cycle();
      check("reset_q", {16'h0, q}, 32'h0);
      check("reset_tc", {31'h0, tc}, 32'h0);
      rst = 1'b0;
      tick_cnt = 0;
      repeat (4) rise_pulse();
      check("edge_q", {16'h0, q}, 32'h0004);
      check("edge_ticks", tick_cnt, 4);

      // carry ripple
      load(16'h0999);
      tc_cnt = 0;
      rise_pulse();
      check("carry_q", {16'h0, q}, 32'h1000);
      check("carry_tc", tc_cnt, 0);

      // up boundary
      load(16'h9999);
      tc_cnt = 0;
      rise_pulse();
`ifdef BCD_SATURATE_EN
      check("upwrap_q", {16'h0, q}, 32'h9999);
`else
      check("upwrap_q", {16'h0, q}, 32'h0000);
`endif
      check("upwrap_tc", tc_cnt, 1);

      // down borrow and down boundary
      up = 1'b0;
      load(16'h1000);
      rise_pulse();
      check("borrow_q", {16'h0, q}, 32'h0999);
      load(16'h0000);
      tc_cnt = 0;
      rise_pulse();
`ifdef BCD_SATURATE_EN
      check("dnwrap_q", {16'h0, q}, 32'h0000);
`else
      check("dnwrap_q", {16'h0, q}, 32'h9999);
`endif
      check("dnwrap_tc", tc_cnt, 1);

      // load wins over a coincident rise, digits clamped
      up = 1'b1;
      tc_cnt = 0;
      sl = 1'b1;
      cycle();
      load(16'hA3F5);
      sl = 1'b0;
      repeat (3) cycle();
      check("ldprio_q", {16'h0, q}, 32'h9395);
      check("ldprio_tc", tc_cnt, 0);

      // enable low: ticks still seen, no counting
      en = 1'b0;
      tick_cnt = 0;
      repeat (5) rise_pulse();
      check("en0_q", {16'h0, q}, 32'h9395);
      check("en0_ticks", tick_cnt, 5);
      en = 1'b1;

      // reset while slow_in high, edge counted after release
      load(16'h0042);
      sl = 1'b1; rst = 1'b1;
      cycle();
      check("midrst_q", {16'h0, q}, 32'h0000);
      rst = 1'b0;
      repeat (3) cycle();
      check("midrst_rise_q", {16'h0, q}, 32'h0001);
      sl = 1'b0;
      repeat (2) cycle();

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 2) == 0) sl = ~sl;
         en = ($urandom_range(0, 7) != 0);
         ld = ($urandom_range(0, 19) == 0);
         up = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       d = 16'h9999;
            1:       d = 16'h0000;
            2:       d = 16'h9990 | 16'($urandom_range(0, 15));
            default: d = 16'($urandom);
         endcase
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
